sha256_message_arbiter: RTL

//  Shares one sha256_hash_compression engine between NUM_REQ requesters.
//  - Arbitrates round-robin at message granularity: a grant is held from the

---
 rtl/sha256_message_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha256_message_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression engine between NUM_REQ
// requesters. A grant covers a whole message. The owner of every issued message
// is queued so that each digest is routed back to the requester it belongs to.
module sha256_message_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ID_FIFO_DEPTH = 4,
    localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic                   sync_rst,
    input  logic [NUM_REQ*512-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]     req_data_in_last,
    input  logic [NUM_REQ-1:0]     req_data_in_valid,
    output logic [NUM_REQ-1:0]     req_data_in_ready,
    output logic [511:0]           eng_data_out,
    output logic                   eng_data_out_last,
    output logic                   eng_data_out_valid,
    input  logic                   eng_data_out_ready,
    input  logic [255:0]           eng_data_in,
    input  logic                   eng_data_in_last,
    input  logic                   eng_data_in_valid,
    output logic                   eng_data_in_ready,
    output logic [255:0]           req_data_out,
    output logic [ID_W-1:0]        req_data_out_id,
    output logic [NUM_REQ-1:0]     req_data_out_valid,
    input  logic [NUM_REQ-1:0]     req_data_out_ready
);

    localparam int unsigned PTR_W = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(ID_FIFO_DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   fifo_mem_q [ID_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              act;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ID_W-1:0]   head;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              push;
    logic              pop;

    // The engine's last flag is redundant: one digest is produced per message.
    logic unused_eng_last;
    assign unused_eng_last = eng_data_in_last;

    // Handshakes only complete while enabled and not being reset.
    assign act        = en && !sync_rst;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(ID_FIFO_DEPTH));
    assign head       = fifo_mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ID_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pick the first valid requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_found && req_data_in_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Block forwarding from the granted requester to the engine while BUSY.
    always_comb begin
        eng_data_out       = '0;
        eng_data_out_last  = 1'b0;
        eng_data_out_valid = 1'b0;
        req_data_in_ready  = '0;
        push               = 1'b0;
        if (state_q == StBusy) begin
            eng_data_out      = req_data_in[int'(grant_q)*512 +: 512];
            eng_data_out_last = req_data_in_last[grant_q];
            if (act) begin
                eng_data_out_valid         = req_data_in_valid[grant_q];
                req_data_in_ready[grant_q] = eng_data_out_ready;
                push = req_data_in_valid[grant_q] && eng_data_out_ready
                       && req_data_in_last[grant_q];
            end
        end
    end

    // Digest routing to the owner at the head of the ID FIFO.
    always_comb begin
        req_data_out       = '0;
        req_data_out_id    = '0;
        req_data_out_valid = '0;
        eng_data_in_ready  = 1'b0;
        pop                = 1'b0;
        if (!fifo_empty) begin
            req_data_out    = eng_data_in;
            req_data_out_id = head;
            if (act) begin
                req_data_out_valid[head] = eng_data_in_valid;
                eng_data_in_ready        = req_data_out_ready[head];
                pop = eng_data_in_valid && req_data_out_ready[head];
            end
        end
    end

    // Next-state logic for the grant FSM and the ID FIFO pointers.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                // A full FIFO blocks new grants so the eventual push cannot overflow.
                if (act && pick_found && !fifo_full) begin
                    grant_d = pick_id;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (push) begin
                    rr_ptr_d = grant_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // State registers; sync_rst also abandons any partial message.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sync_rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID FIFO storage; entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= grant_q;
    end

endmodule
